// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store engine. Accepts MemRead/MemWrite/BE/funct3 from
//   the EX/MEM register, runs a req/ack handshake with a variable-latency
//   data memory, steers store bytes onto the proper lanes, and aligns plus
//   sign/zero-extends load data. Holds the pipeline in stall while a request
//   is outstanding and aborts after TIMEOUT_CYCLES without an ack.
//
// Ports
//   i_clk, i_rst         clock (rising edge), async active-high reset
//   i_valid              EX/MEM holds a live instruction
//   i_mem_read/_write    load / store request (write wins when both set)
//   i_be                 access width: 0001 byte, 0011 half, 1111 word
//   i_funct3             bit 2 selects unsigned load
//   i_addr, i_wdata      byte address, right-justified store data
//   o_stall              freeze upstream pipeline registers
//   o_rdata              aligned, extended load result (held between loads)
//   o_rdata_valid        one-cycle pulse, load result valid
//   o_misalign           one-cycle pulse, access rejected
//   o_timeout            one-cycle pulse, memory never acked
//   o_dm_*               data-memory request side
//   i_dm_ack, i_dm_rdata data-memory completion and read data
module load_store_unit #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [3:0]        i_be,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_stall,
   output logic [31:0]       o_rdata,
   output logic              o_rdata_valid,
   output logic              o_misalign,
   output logic              o_timeout,
   output logic              o_dm_req,
   output logic              o_dm_we,
   output logic [ADDR_W-1:0] o_dm_addr,
   output logic [3:0]        o_dm_be,
   output logic [31:0]       o_dm_wdata,
   input  logic              i_dm_ack,
   input  logic [31:0]       i_dm_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_dm_addr;
   logic [3:0]        r_dm_be;
   logic [31:0]       r_dm_wdata;
   logic              r_uns;
   logic [1:0]        r_lane;
   logic              r_word;
   logic              r_half;
   logic              r_to;
   logic [31:0]       r_rdata;

   logic              w_start;
   logic              w_mis;
   logic [31:0]       w_shift;
   logic [31:0]       w_load_ext;
   logic              w_unused;

   assign w_unused = ^{i_funct3[1:0], i_addr[31:ADDR_W+2]};

   assign w_start = i_valid & (i_mem_read | i_mem_write);

   always_comb begin
      w_mis = 1'b1;
      case (i_be)
         4'b0001: w_mis = 1'b0;
         4'b0011: w_mis = i_addr[0];
         4'b1111: w_mis = |i_addr[1:0];
         default: w_mis = 1'b1;
      endcase
   end

   assign w_shift = i_dm_rdata >> {r_lane, 3'b000};

   always_comb begin
      if (r_word) begin
         w_load_ext = w_shift;
      end else if (r_half) begin
         w_load_ext = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      end else begin
         w_load_ext = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
      end
   end

   // IDLE-state outputs depend on live inputs, so they are masked by reset
   // to keep every output low while reset is held.
   always_comb begin
      w_state_nxt   = r_state;
      o_stall       = 1'b0;
      o_misalign    = 1'b0;
      o_dm_req      = 1'b0;
      o_rdata_valid = 1'b0;
      o_timeout     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start && !i_rst) begin
               if (w_mis) begin
                  o_misalign = 1'b1;
               end else begin
                  o_stall     = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            o_dm_req = 1'b1;
            o_stall  = 1'b1;
            if (i_dm_ack || (r_cnt == CNT_LAST)) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            o_rdata_valid = ~r_to & ~r_we;
            o_timeout     = r_to;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_be    <= '0;
         r_dm_wdata <= '0;
         r_uns      <= 1'b0;
         r_lane     <= '0;
         r_word     <= 1'b0;
         r_half     <= 1'b0;
         r_to       <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_start && !w_mis) begin
                  r_we       <= i_mem_write;
                  r_dm_addr  <= i_addr[ADDR_W+1:2];
                  r_dm_be    <= i_be << i_addr[1:0];
                  r_dm_wdata <= i_wdata << {i_addr[1:0], 3'b000};
                  r_uns      <= i_funct3[2];
                  r_lane     <= i_addr[1:0];
                  r_word     <= i_be[3];
                  r_half     <= i_be[1] & ~i_be[3];
                  r_cnt      <= '0;
                  r_to       <= 1'b0;
               end
            end
            S_WAIT: begin
               // An ack in the expiry cycle wins over the timeout.
               if (i_dm_ack) begin
                  r_to <= 1'b0;
                  if (!r_we) begin
                     r_rdata <= w_load_ext;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  r_to    <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_rdata    = r_rdata;
   assign o_dm_we    = r_we;
   assign o_dm_addr  = r_dm_addr;
   assign o_dm_be    = r_dm_be;
   assign o_dm_wdata = r_dm_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed and randomized accesses against a behavioural model of the
//   load/store unit, run with a short memory timeout (4 cycles).
module tb_load_store_unit;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  be;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        misalign;
   logic        timeout;
   logic        dm_req;
   logic        dm_we;
   logic [11:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   int unsigned n_chk;
   int unsigned n_bad;
   logic [31:0] last_rdata;
   logic [31:0] got;

   load_store_unit #(
      .ADDR_W         (12),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (valid),
      .i_mem_read    (mem_read),
      .i_mem_write   (mem_write),
      .i_be          (be),
      .i_funct3      (funct3),
      .i_addr        (addr),
      .i_wdata       (wdata),
      .o_stall       (stall),
      .o_rdata       (rdata),
      .o_rdata_valid (rdata_valid),
      .o_misalign    (misalign),
      .o_timeout     (timeout),
      .o_dm_req      (dm_req),
      .o_dm_we       (dm_we),
      .o_dm_addr     (dm_addr),
      .o_dm_be       (dm_be),
      .o_dm_wdata    (dm_wdata),
      .i_dm_ack      (dm_ack),
      .i_dm_rdata    (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Load result from the rules: pick the addressed bytes, then extend.
   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [3:0] b,
                                              input logic [1:0] ln, input bit uns);
      logic [31:0] s;
      logic [31:0] v;
      s = w >> (8 * ln);
      if (b == 4'b1111) begin
         v = s;
      end else if (b == 4'b0011) begin
         v = s & 32'h0000_FFFF;
         if (!uns && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
      end else begin
         v = s & 32'h0000_00FF;
         if (!uns && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
      end
      return v;
   endfunction

   // One access. ackdly = number of WAIT cycles before the ack cycle;
   // ackdly >= TO means memory never acks.
   task automatic do_access(input bit v, input bit rd, input bit wr, input logic [3:0] b,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int unsigned ackdly,
                            output logic [31:0] obs_rdata);
      bit          start;
      bit          mis;
      bit          ok;
      bit          done;
      logic [1:0]  ln;
      logic [31:0] exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_addr;
      ln       = a[1:0];
      start    = v && (rd || wr);
      mis      = !((b == 4'b0001) || (b == 4'b0011 && !a[0]) || (b == 4'b1111 && ln == 2'd0));
      exp_be   = (32'(b) << ln) & 32'hF;
      exp_wd   = wd << (8 * ln);
      exp_addr = (a >> 2) & 32'hFFF;
      ok       = (ackdly < TO);

      @(negedge clk);
      valid = v; mem_read = rd; mem_write = wr; be = b; funct3 = f3;
      addr = a; wdata = wd; dm_ack = 1'b0; dm_rdata = $urandom;
      #1;
      if (!start) begin
         chk("idle_stall", 32'(stall), 0);
         chk("idle_mis", 32'(misalign), 0);
         @(negedge clk); #1;
         chk("idle_req", 32'(dm_req), 0);
      end else if (mis) begin
         chk("mis_pulse", 32'(misalign), 1);
         chk("mis_stall", 32'(stall), 0);
         chk("mis_req0", 32'(dm_req), 0);
         @(negedge clk); #1;
         chk("mis_req1", 32'(dm_req), 0);
         chk("mis_stall1", 32'(stall), 0);
      end else begin
         chk("start_stall", 32'(stall), 1);
         chk("start_req", 32'(dm_req), 0);
         chk("start_mis", 32'(misalign), 0);
         done = 1'b0;
         for (int k = 0; k < int'(TO) && !done; k++) begin
            @(negedge clk);
            dm_ack   = (k == int'(ackdly));
            dm_rdata = (k == int'(ackdly)) ? rdat : $urandom;
            #1;
            chk("wait_req", 32'(dm_req), 1);
            chk("wait_stall", 32'(stall), 1);
            chk("wait_we", 32'(dm_we), 32'(wr));
            chk("wait_addr", 32'(dm_addr), exp_addr);
            chk("wait_be", 32'(dm_be), exp_be);
            chk("wait_wdata", dm_wdata, exp_wd);
            if (k == int'(ackdly)) done = 1'b1;
         end
         @(negedge clk);
         dm_ack   = 1'($urandom_range(0, 1));
         dm_rdata = $urandom;
         #1;
         chk("resp_stall", 32'(stall), 0);
         chk("resp_req", 32'(dm_req), 0);
         if (ok) begin
            if (!wr) last_rdata = model_load(rdat, b, ln, f3[2]);
            chk("resp_valid", 32'(rdata_valid), wr ? 0 : 1);
            chk("resp_timeout", 32'(timeout), 0);
         end else begin
            last_rdata = '0;
            chk("resp_valid", 32'(rdata_valid), 0);
            chk("resp_timeout", 32'(timeout), 1);
         end
         chk("resp_rdata", rdata, last_rdata);
      end
      obs_rdata = rdata;
   endtask

   initial begin
      n_chk = 0; n_bad = 0; last_rdata = '0;
      rst = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; be = '0;
      funct3 = '0; addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(dm_req), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rvalid", 32'(rdata_valid), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_mis", 32'(misalign), 0);
      chk("rst_we", 32'(dm_we), 0);
      chk("rst_be", 32'(dm_be), 0);
      chk("rst_wdata", dm_wdata, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // SW 0x10, ack on third WAIT cycle; then same with read+write both set
      do_access(1, 0, 1, 4'b1111, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2, got);
      do_access(1, 1, 1, 4'b1111, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2, got);
      // LB / LBU at 0x13
      do_access(1, 1, 0, 4'b0001, 3'b000, 32'h13, 32'h0, 32'h80123456, 0, got);
      chk("lb_const", got, 32'hFFFFFF80);
      do_access(1, 1, 0, 4'b0001, 3'b100, 32'h13, 32'h0, 32'h80123456, 0, got);
      chk("lbu_const", got, 32'h00000080);
      // LH / SH at 0x22
      do_access(1, 1, 0, 4'b0011, 3'b001, 32'h22, 32'h0, 32'h80011234, 1, got);
      chk("lh_const", got, 32'hFFFF8001);
      do_access(1, 0, 1, 4'b0011, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 0, got);
      chk("sh_keeps_rdata", got, 32'hFFFF8001);
      // Misaligned
      do_access(1, 1, 0, 4'b1111, 3'b010, 32'h06, 32'h0, 32'h0, 0, got);
      do_access(1, 1, 0, 4'b0011, 3'b001, 32'h01, 32'h0, 32'h0, 0, got);
      // Timeout, then ack in the expiry cycle
      do_access(1, 1, 0, 4'b1111, 3'b010, 32'h40, 32'h0, 32'h12345678, 9, got);
      chk("to_rdata_zero", got, 32'h0);
      do_access(1, 1, 0, 4'b1111, 3'b010, 32'h40, 32'h0, 32'h12345678, TO - 1, got);
      chk("late_ack_rdata", got, 32'h12345678);

      // Reset one cycle into WAIT
      @(negedge clk);
      valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; be = 4'b1111; funct3 = 3'b010;
      addr = 32'h08; dm_ack = 1'b0;
      @(negedge clk); #1;
      chk("pre_rst_req", 32'(dm_req), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(dm_req), 0);
      chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_rvalid", 32'(rdata_valid), 0);
      chk("mid_rst_timeout", 32'(timeout), 0);
      valid = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      do_access(1, 1, 0, 4'b1111, 3'b010, 32'h08, 32'h0, 32'hCAFEF00D, 1, got);
      chk("post_rst_lw", got, 32'hCAFEF00D);

      // Randomized accesses
      for (int i = 0; i < 80; i++) begin
         logic [3:0] rb;
         int unsigned sel;
         sel = $urandom_range(0, 7);
         case (sel)
            0, 1:    rb = 4'b0001;
            2, 3:    rb = 4'b0011;
            4, 5:    rb = 4'b1111;
            default: rb = 4'($urandom);
         endcase
         do_access(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), rb,
                   3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5), got);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
